// File: rtl/clock_set_ctrl.sv
// Run/set controller for a BCD digital clock: issues count enables,
// seconds clear, mode code, set-field blink and top-of-hour chime.
//
// Ports:
//   CP      clock, rising edge
//   CR      synchronous active-high reset
//   TICK    1 Hz strobe, one CP cycle wide
//   MODE    button pulse, cycles RUN -> SET_HR -> SET_MIN -> RUN
//   ADJ     button pulse, bumps the field being set
//   SecH/SecL, MinH/MinL, HrH/HrL  BCD digits from the external counters
//   EnSec/EnMin/EnHr  registered count enables (one-cycle pulses)
//   ClrSec  registered seconds clear pulse (leaving SET_MIN by MODE)
//   Mode    state code: 0 RUN, 1 SET_HR, 2 SET_MIN
//   Blink   flash for the field being set
//   Chime   high during the last ten seconds of each hour in RUN
module clock_set_ctrl #(
  parameter int unsigned SET_TIMEOUT = 60
) (
  input  logic       CP,
  input  logic       CR,
  input  logic       TICK,
  input  logic       MODE,
  input  logic       ADJ,
  input  logic [3:0] SecH,
  input  logic [3:0] SecL,
  input  logic [3:0] MinH,
  input  logic [3:0] MinL,
  input  logic [3:0] HrH,
  input  logic [3:0] HrL,
  output logic       EnSec,
  output logic       EnMin,
  output logic       EnHr,
  output logic       ClrSec,
  output logic [1:0] Mode,
  output logic       Blink,
  output logic       Chime
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2,
    ILLEGAL = 2'd3
  } state_e;

  localparam logic [7:0] TMO = 8'(SET_TIMEOUT);

  state_e     state_q, state_d;
  logic [7:0] idle_q, idle_d;
  logic       blink_q, blink_d;
  logic       en_sec_q, en_sec_d;
  logic       en_min_q, en_min_d;
  logic       en_hr_q, en_hr_d;
  logic       clr_q, clr_d;
  logic       chime_q, chime_d;

  logic       sec59;
  logic       min59;
  logic [7:0] idle_inc;

  // Hour digits only matter to the external counter; the hour carry
  // is decided from seconds and minutes alone.
  logic [7:0] hr_unused;
  assign hr_unused = {HrH, HrL};

  assign sec59    = ({SecH, SecL} == 8'h59);
  assign min59    = ({MinH, MinL} == 8'h59);
  assign idle_inc = idle_q + 8'd1;

  always_comb begin
    state_d  = state_q;
    idle_d   = idle_q;
    blink_d  = blink_q;
    en_sec_d = 1'b0;
    en_min_d = 1'b0;
    en_hr_d  = 1'b0;
    clr_d    = 1'b0;
    chime_d  = (state_q == RUN) && min59
               && (SecH == 4'h5);

    unique case (state_q)
      RUN: begin
        blink_d = 1'b0;
        idle_d  = 8'd0;
        if (TICK) begin
          en_sec_d = 1'b1;
          en_min_d = sec59;
          en_hr_d  = sec59 && min59;
        end
        if (MODE) begin
          state_d = SET_HR;
          blink_d = 1'b1;
        end
      end
      SET_HR, SET_MIN: begin
        if (MODE) begin
          // MODE wins over ADJ; TICK is frozen out
          idle_d = 8'd0;
          if (state_q == SET_HR) begin
            state_d = SET_MIN;
            blink_d = 1'b1;
          end else begin
            state_d = RUN;
            blink_d = 1'b0;
            clr_d   = 1'b1;
          end
        end else begin
          if (TICK) blink_d = ~blink_q;
          if (ADJ) begin
            idle_d   = 8'd0;
            en_hr_d  = (state_q == SET_HR);
            en_min_d = (state_q == SET_MIN);
          end else if (TICK) begin
            if (idle_inc == TMO) begin
              // quiet timeout: back to RUN, no seconds clear
              state_d = RUN;
              idle_d  = 8'd0;
              blink_d = 1'b0;
            end else begin
              idle_d = idle_inc;
            end
          end
        end
      end
      ILLEGAL: begin
        state_d = RUN;
        idle_d  = 8'd0;
        blink_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CP) begin
    if (CR) begin
      state_q  <= RUN;
      idle_q   <= 8'd0;
      blink_q  <= 1'b0;
      en_sec_q <= 1'b0;
      en_min_q <= 1'b0;
      en_hr_q  <= 1'b0;
      clr_q    <= 1'b0;
      chime_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idle_q   <= idle_d;
      blink_q  <= blink_d;
      en_sec_q <= en_sec_d;
      en_min_q <= en_min_d;
      en_hr_q  <= en_hr_d;
      clr_q    <= clr_d;
      chime_q  <= chime_d;
    end
  end

  assign EnSec  = en_sec_q;
  assign EnMin  = en_min_q;
  assign EnHr   = en_hr_q;
  assign ClrSec = clr_q;
  assign Mode   = state_q;
  assign Blink  = blink_q;
  assign Chime  = chime_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with BCD mod-60/mod-24
// counter models closing the loop on the enables.
module tb_clock_set_ctrl;

  logic       CP = 1'b0;
  logic       CR = 1'b1;
  logic       TICK = 1'b0;
  logic       MODE = 1'b0;
  logic       ADJ = 1'b0;
  logic       EnSec, EnMin, EnHr, ClrSec;
  logic       Blink, Chime;
  logic [1:0] Mode;

  logic [7:0] sec, mn, hr;
  logic       ld = 1'b0;
  logic [7:0] ld_s = 8'h0;
  logic [7:0] ld_m = 8'h0;
  logic [7:0] ld_h = 8'h0;

  int nasrt = 0;
  int nfail = 0;

  clock_set_ctrl #(.SET_TIMEOUT(3)) dut (
    .CP(CP), .CR(CR), .TICK(TICK),
    .MODE(MODE), .ADJ(ADJ),
    .SecH(sec[7:4]), .SecL(sec[3:0]),
    .MinH(mn[7:4]), .MinL(mn[3:0]),
    .HrH(hr[7:4]), .HrL(hr[3:0]),
    .EnSec(EnSec), .EnMin(EnMin), .EnHr(EnHr),
    .ClrSec(ClrSec), .Mode(Mode),
    .Blink(Blink), .Chime(Chime)
  );

  always #5 CP = ~CP;

  function automatic logic [7:0] bump(
    input logic [7:0] v, input logic [7:0] top);
    logic [3:0] hi, lo;
    hi = v[7:4];
    lo = v[3:0];
    if (v == top) return 8'h00;
    if (lo == 4'd9) return {hi + 4'd1, 4'd0};
    return {hi, lo + 4'd1};
  endfunction

  always_ff @(posedge CP) begin
    if (ld) begin
      sec <= ld_s;
      mn  <= ld_m;
      hr  <= ld_h;
    end else begin
      if (ClrSec) sec <= 8'h00;
      else if (EnSec) sec <= bump(sec, 8'h59);
      if (EnMin) mn <= bump(mn, 8'h59);
      if (EnHr) hr <= bump(hr, 8'h23);
    end
  end

  task automatic cyc(input logic t, input logic m,
                     input logic a);
    @(negedge CP);
    TICK = t;
    MODE = m;
    ADJ  = a;
    @(posedge CP);
    #1;
  endtask

  task automatic settime(input logic [7:0] h,
                         input logic [7:0] m,
                         input logic [7:0] s);
    @(negedge CP);
    TICK = 1'b0;
    MODE = 1'b0;
    ADJ  = 1'b0;
    ld   = 1'b1;
    ld_h = h;
    ld_m = m;
    ld_s = s;
    @(posedge CP);
    #1;
    ld = 1'b0;
  endtask

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    nasrt++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  initial begin
    // reset state
    settime(8'h12, 8'h59, 8'h58);
    cyc(1'b1, 1'b1, 1'b1);
    chk("rst_mode", 8'(Mode), 8'h0);
    chk("rst_en", {5'b0, EnSec, EnMin, EnHr}, 8'h0);
    chk("rst_clr", 8'(ClrSec), 8'h0);
    chk("rst_blink", 8'(Blink), 8'h0);
    chk("rst_chime", 8'(Chime), 8'h0);
    CR = 1'b0;

    // 12:59:58 -> 13:00:00
    cyc(1'b1, 1'b0, 1'b0);
    chk("t1_en", {5'b0, EnSec, EnMin, EnHr}, 8'h4);
    cyc(1'b0, 1'b0, 1'b0);
    chk("t1_pulse", 8'(EnSec), 8'h0);
    chk("t1_sec", sec, 8'h59);
    cyc(1'b1, 1'b0, 1'b0);
    chk("t2_en", {5'b0, EnSec, EnMin, EnHr}, 8'h7);
    cyc(1'b0, 1'b0, 1'b0);
    chk("t2_en_off", {5'b0, EnSec, EnMin, EnHr}, 8'h0);
    chk("t2_time", hr, 8'h13);
    chk("t2_min", mn, 8'h00);
    chk("t2_sec", sec, 8'h00);

    // 23:59:50 .. 59 chime, then wrap to 00:00:00
    settime(8'h23, 8'h59, 8'h50);
    cyc(1'b0, 1'b0, 1'b0);
    chk("ch_50", 8'(Chime), 8'h1);
    for (int i = 0; i < 9; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      chk("ch_run", 8'(Chime), 8'h1);
    end
    chk("ch_sec59", sec, 8'h59);
    cyc(1'b1, 1'b0, 1'b0);
    chk("wrap_en", {5'b0, EnSec, EnMin, EnHr}, 8'h7);
    cyc(1'b0, 1'b0, 1'b0);
    chk("wrap_hr", hr, 8'h00);
    chk("wrap_min", mn, 8'h00);
    chk("wrap_sec", sec, 8'h00);
    cyc(1'b0, 1'b0, 1'b0);
    chk("ch_off", 8'(Chime), 8'h0);

    // SET_HR: 3 ADJ from 22 -> 01, ticks frozen
    settime(8'h22, 8'h15, 8'h30);
    cyc(1'b0, 1'b1, 1'b0);
    chk("shr_mode", 8'(Mode), 8'h1);
    chk("shr_blink", 8'(Blink), 8'h1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b1);
      chk("shr_adj", {5'b0, EnSec, EnMin, EnHr}, 8'h1);
      cyc(1'b1, 1'b0, 1'b0);
      chk("shr_tick", {5'b0, EnSec, EnMin, EnHr}, 8'h0);
    end
    chk("shr_hr", hr, 8'h01);
    chk("shr_min", mn, 8'h15);
    chk("shr_sec", sec, 8'h30);

    // SET_MIN at 10:58:37, 2 ADJ then MODE
    cyc(1'b0, 1'b1, 1'b0);
    chk("smin_mode", 8'(Mode), 8'h2);
    settime(8'h10, 8'h58, 8'h37);
    cyc(1'b0, 1'b0, 1'b1);
    chk("smin_adj", {5'b0, EnSec, EnMin, EnHr}, 8'h2);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("smin_min", mn, 8'h00);
    chk("smin_hr", hr, 8'h10);
    cyc(1'b0, 1'b1, 1'b0);
    chk("smin_clr", 8'(ClrSec), 8'h1);
    chk("smin_run", 8'(Mode), 8'h0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("smin_clr_off", 8'(ClrSec), 8'h0);
    chk("smin_sec", sec, 8'h00);
    chk("smin_hr2", hr, 8'h10);

    // ADJ in RUN ignored
    cyc(1'b0, 1'b0, 1'b1);
    chk("run_adj", {5'b0, EnSec, EnMin, EnHr}, 8'h0);

    // timeout of 3 ticks, blink 1,0,1,0
    cyc(1'b0, 1'b1, 1'b0);
    chk("to_mode", 8'(Mode), 8'h1);
    chk("to_b0", 8'(Blink), 8'h1);
    cyc(1'b1, 1'b0, 1'b0);
    chk("to_b1", 8'(Blink), 8'h0);
    chk("to_nosec", 8'(EnSec), 8'h0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("to_b2", 8'(Blink), 8'h1);
    chk("to_mode2", 8'(Mode), 8'h1);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("to_run", 8'(Mode), 8'h0);
    chk("to_b3", 8'(Blink), 8'h0);
    chk("to_clr", 8'(ClrSec), 8'h0);

    // MODE+ADJ together, then reset with TICK
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1);
    chk("ma_mode", 8'(Mode), 8'h2);
    chk("ma_en", {5'b0, EnSec, EnMin, EnHr}, 8'h0);
    CR = 1'b1;
    cyc(1'b1, 1'b0, 1'b1);
    CR = 1'b0;
    chk("cr_mode", 8'(Mode), 8'h0);
    chk("cr_out",
        {2'b0, EnSec, EnMin, EnHr, ClrSec, Blink, Chime},
        8'h0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("post_rst", {5'b0, EnSec, EnMin, EnHr}, 8'h4);
    cyc(1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nasrt, nfail);
    $finish;
  end

endmodule
